// File: rtl/caxi4interconnect_push_pkg.sv
// Shared definitions for the push-side FIFO controllers.
// Also holds the occupancy-update rule that the read-side controllers reuse.
package caxi4interconnect_push_pkg;

    localparam int unsigned FIFO_DEPTH_DEF = 16;
    localparam int unsigned LEVEL_MAX      = FIFO_DEPTH_DEF;

    // Number of bits needed to encode values 0..v-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    // Next occupancy: a push is held at max, and a pop at zero is ignored.
    function automatic int unsigned level_update(input int unsigned level,
                                                 input logic push,
                                                 input logic pop,
                                                 input int unsigned max);
        int unsigned n;
        n = level;
        if (push && (n < max)) n = n + 1;
        if (pop && (level != 0)) n = n - 1;
        return n;
    endfunction

endpackage

// File: rtl/caxi4interconnect_push_level_cnt.sv
// FIFO occupancy tracker driven by our own pushes and the reader's pops.
// Provides a registered full flag and a sticky underflow error.
module caxi4interconnect_push_level_cnt
    import caxi4interconnect_push_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = LEVEL_MAX,
    parameter int unsigned CNT_WIDTH  = clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr,
    input  logic                 i_rd,
    output logic [CNT_WIDTH-1:0] o_level,
    output logic                 o_full,
    output logic                 o_err
);

    logic [CNT_WIDTH-1:0] r_level;
    logic                 r_full;
    logic                 r_err;
    logic [CNT_WIDTH-1:0] w_level_next;

    always_comb begin
        w_level_next = CNT_WIDTH'(level_update(32'(r_level), i_wr, i_rd, FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_level <= w_level_next;
            r_full  <= (w_level_next == CNT_WIDTH'(FIFO_DEPTH));
            if (i_rd && (r_level == '0)) r_err <= 1'b1;
        end
    end

    assign o_level = r_level;
    assign o_full  = r_full;
    assign o_err   = r_err;

endmodule

// File: rtl/caxi4interconnect_push_reg_ctrl.sv
// Write-side controller: valid/ready source into a one-entry skid, pushing
// into a same-clock FIFO whose occupancy is tracked locally.
module caxi4interconnect_push_reg_ctrl
    import caxi4interconnect_push_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = LEVEL_MAX,
    parameter int unsigned CNT_WIDTH  = clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_src_data_valid,
    input  logic [DATA_WIDTH-1:0] i_src_data,
    output logic                  o_src_ready,
    input  logic                  i_fifo_rd_en,
    output logic                  o_fifo_wr_en,
    output logic [DATA_WIDTH-1:0] o_fifo_wr_data,
    output logic [CNT_WIDTH-1:0]  o_fifo_level,
    output logic                  o_fifo_full,
    output logic                  o_err_underflow
);

    logic                  r_src_ready;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  w_accept;
    logic                  w_space;
    logic                  w_wr_en;
    logic                  w_skid_valid_next;
    logic [CNT_WIDTH-1:0]  w_level;

    // Space uses only the registered level, so a pop never feeds the push path.
    assign w_accept = i_src_data_valid & r_src_ready;
    assign w_space  = (w_level < CNT_WIDTH'(FIFO_DEPTH));
    assign w_wr_en  = (r_skid_valid | w_accept) & w_space;

    always_comb begin
        w_skid_valid_next = r_skid_valid;
        if (w_accept && !w_space)          w_skid_valid_next = 1'b1;
        else if (r_skid_valid && w_space)  w_skid_valid_next = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src_ready  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else begin
            r_src_ready  <= !w_skid_valid_next;
            r_skid_valid <= w_skid_valid_next;
            if (w_accept && !w_space) r_skid_data <= i_src_data;
        end
    end

    caxi4interconnect_push_level_cnt #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_level_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_wr_en),
        .i_rd    (i_fifo_rd_en),
        .o_level (w_level),
        .o_full  (o_fifo_full),
        .o_err   (o_err_underflow)
    );

    assign o_src_ready    = r_src_ready;
    assign o_fifo_wr_en   = w_wr_en;
    assign o_fifo_wr_data = r_skid_valid ? r_skid_data : i_src_data;
    assign o_fifo_level   = w_level;

endmodule

// File: tb/tb_caxi4interconnect_push_reg_ctrl.sv
// Directed bench for the push controller with a 4-entry FIFO.
module tb_caxi4interconnect_push_reg_ctrl;

    localparam int unsigned DW = 64;
    localparam int unsigned FD = 4;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          rd_en;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [CW-1:0] level;
    logic          full;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    caxi4interconnect_push_reg_ctrl #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_src_data_valid (src_valid),
        .i_src_data       (src_data),
        .o_src_ready      (src_ready),
        .i_fifo_rd_en     (rd_en),
        .o_fifo_wr_en     (wr_en),
        .o_fifo_wr_data   (wr_data),
        .o_fifo_level     (level),
        .o_fifo_full      (full),
        .o_err_underflow  (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, apply inputs, then let combinational outputs settle.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        @(posedge clk);
        #1;
        src_valid = v;
        src_data  = d;
        rd_en     = r;
        #1;
    endtask

    // Status check: ready, write enable, level, full.
    task automatic chk_st(input string tag, input logic rdy, input logic we,
                          input logic [CW-1:0] lv, input logic fl);
        check({tag, ".ready"}, 64'(src_ready), 64'(rdy));
        check({tag, ".wr_en"}, 64'(wr_en), 64'(we));
        check({tag, ".level"}, 64'(level), 64'(lv));
        check({tag, ".full"},  64'(full), 64'(fl));
    endtask

    initial begin
        rst = 1'b0; src_valid = 1'b0; src_data = '0; rd_en = 1'b0;

        // 1: reset then idle
        repeat (3) step(1'b0, '0, 1'b0);
        chk_st("rst", 1'b0, 1'b0, 3'd0, 1'b0);
        check("rst.err", 64'(err), 64'd0);
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        chk_st("rel", 1'b1, 1'b0, 3'd0, 1'b0);

        // 2: streaming fill, words 1..4 pass straight through
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 64'(i), 1'b0);
            chk_st($sformatf("fill%0d", i), 1'b1, 1'b1, CW'(i - 1), 1'b0);
            check($sformatf("fill%0d.data", i), wr_data, 64'(i));
        end
        step(1'b1, 64'h5, 1'b0);
        chk_st("skid_in", 1'b1, 1'b0, 3'd4, 1'b1);
        step(1'b1, 64'h6, 1'b0);
        chk_st("stall", 1'b0, 1'b0, 3'd4, 1'b1);

        // 3: one pop while full, skid word follows next cycle
        step(1'b1, 64'h6, 1'b1);
        chk_st("pop", 1'b0, 1'b0, 3'd4, 1'b1);
        step(1'b1, 64'h6, 1'b0);
        chk_st("drain", 1'b0, 1'b1, 3'd3, 1'b0);
        check("drain.data", wr_data, 64'h5);
        step(1'b0, '0, 1'b0);
        chk_st("refull", 1'b1, 1'b0, 3'd4, 1'b1);

        // pop down to level 2
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk_st("lvl2", 1'b1, 1'b0, 3'd2, 1'b0);

        // 4: simultaneous push and pop at level 2
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 64'h100 + 64'(i), 1'b1);
            chk_st($sformatf("pp%0d", i), 1'b1, 1'b1, 3'd2, 1'b0);
            check($sformatf("pp%0d.data", i), wr_data, 64'h100 + 64'(i));
        end

        // 5: drain to empty, then pop at zero
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk_st("empty", 1'b1, 1'b0, 3'd0, 1'b0);
        check("empty.err", 64'(err), 64'd0);
        step(1'b0, '0, 1'b1);
        step(1'b1, 64'h77, 1'b0);
        chk_st("uflow", 1'b1, 1'b1, 3'd0, 1'b0);
        check("uflow.err", 64'(err), 64'd1);
        step(1'b0, '0, 1'b0);
        check("uflow.lvl", 64'(level), 64'd1);
        check("uflow.sticky", 64'(err), 64'd1);

        // reset clears the sticky error; no writes while in reset
        rst = 1'b0;
        step(1'b1, 64'h99, 1'b0);
        chk_st("rst2", 1'b0, 1'b0, 3'd0, 1'b0);
        check("rst2.err", 64'(err), 64'd0);
        rst = 1'b1;
        step(1'b0, '0, 1'b0);

        // 6: refill into a stall, then reset asynchronously mid-stall
        for (int i = 1; i <= 5; i++) step(1'b1, 64'(i), 1'b0);
        step(1'b1, 64'h6, 1'b0);
        chk_st("stall2", 1'b0, 1'b0, 3'd4, 1'b1);
        rst = 1'b0;
        #1;
        chk_st("arst", 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b0, '0, 1'b0);
        rst = 1'b1;
        step(1'b1, 64'hA, 1'b0);
        chk_st("post", 1'b1, 1'b1, 3'd0, 1'b0);
        check("post.data", wr_data, 64'hA);
        step(1'b0, '0, 1'b0);
        chk_st("post2", 1'b1, 1'b0, 3'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
